// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer: packs UART byte pairs into RGB565 pixel writes.
// Optional A5 5A header, idle-timeout abort, frame counting.
module uart_pixel_packer #(
  parameter int IMG_PIX     = 65536,
  parameter int TIMEOUT_CYC = 500000,
  parameter bit HDR_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        ram_wren,
  output logic [15:0] ram_wraddr,
  output logic [15:0] ram_wrdata,
  output logic        frame_done,
  output logic        err_timeout,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        LED
);

  typedef enum logic [1:0] {
    IDLE, HDR2, PIX_HI, PIX_LO
  } state_t;

  localparam state_t HOME = HDR_EN ? IDLE : PIX_HI;
  localparam logic [15:0] LAST = 16'(IMG_PIX - 1);
  localparam logic [23:0] TO_END = 24'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic [15:0] pix_cnt, pix_cnt_d;
  logic [23:0] to_cnt;
  logic [7:0]  hi_q, hi_d;
  logic        act, act_d;
  logic        to_run, to_hit;
  logic        wr_go, last_px;

  // timeout arming and pixel-completion qualifiers
  always_comb begin
    to_run  = (state != IDLE) && (HDR_EN || act);
    to_hit  = to_run && !rx_done && (to_cnt == TO_END);
    wr_go   = (state == PIX_LO) && rx_done;
    last_px = wr_go && (pix_cnt == LAST);
  end

  // next state, pixel counter, high-byte latch, frame activity
  always_comb begin
    state_d   = state;
    pix_cnt_d = pix_cnt;
    hi_d      = hi_q;
    act_d     = act;
    if (to_hit) begin
      state_d   = HOME;
      pix_cnt_d = '0;
      hi_d      = '0;
      act_d     = 1'b0;
    end else if (rx_done) begin
      unique case (state)
        IDLE: begin
          if (rx_data == 8'hA5) begin
            state_d = HDR2;
            act_d   = 1'b1;
          end
        end
        HDR2: begin
          if (rx_data == 8'h5A) begin
            state_d   = PIX_HI;
            pix_cnt_d = '0;
          end else if (rx_data != 8'hA5) begin
            state_d = IDLE;
            act_d   = 1'b0;
          end
        end
        PIX_HI: begin
          hi_d    = rx_data;
          state_d = PIX_LO;
          act_d   = 1'b1;
        end
        PIX_LO: begin
          if (last_px) begin
            state_d   = HOME;
            pix_cnt_d = '0;
            act_d     = 1'b0;
          end else begin
            state_d   = PIX_HI;
            pix_cnt_d = pix_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOME;
      pix_cnt <= '0;
      hi_q    <= '0;
      act     <= 1'b0;
    end else begin
      state   <= state_d;
      pix_cnt <= pix_cnt_d;
      hi_q    <= hi_d;
      act     <= act_d;
    end
  end

  // idle timer: restarts on every byte, held clear when not armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (rx_done || !to_run || to_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 24'd1;
  end

  // registered write port and frame status, one cycle after the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wren    <= 1'b0;
      ram_wraddr  <= '0;
      ram_wrdata  <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
      LED         <= 1'b0;
    end else begin
      ram_wren    <= wr_go;
      frame_done  <= last_px;
      err_timeout <= to_hit;
      if (wr_go) begin
        ram_wraddr <= pix_cnt;
        ram_wrdata <= {hi_q, rx_data};
      end
      if (last_px) begin
        frame_cnt <= frame_cnt + 8'd1;
        LED       <= ~LED;
      end
    end
  end

  // busy spans the frame, including its frame_done cycle
  always_comb busy = act | frame_done;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// tb_uart_pixel_packer: directed checks of header, pixel writes,
// frame end, timeout, terminal-cycle race and reset abort.
module tb_uart_pixel_packer;

  localparam int NPIX  = 16;
  localparam int NPIX0 = 4;
  localparam int TO    = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        ram_wren, frame_done, err_timeout, busy, LED;
  logic [15:0] ram_wraddr, ram_wrdata;
  logic [7:0]  frame_cnt;

  logic [7:0]  rx_data0 = '0;
  logic        rx_done0 = 1'b0;
  logic        wren0, fd0, err0, busy0, led0;
  logic [15:0] addr0, data0;
  logic [7:0]  fcnt0;

  int errors = 0;
  int checks = 0;
  logic seen;

  uart_pixel_packer #(
    .IMG_PIX(NPIX), .TIMEOUT_CYC(TO), .HDR_EN(1'b1)
  ) u1 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_done(rx_done),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
    .ram_wrdata(ram_wrdata), .frame_done(frame_done),
    .err_timeout(err_timeout), .busy(busy),
    .frame_cnt(frame_cnt), .LED(LED)
  );

  uart_pixel_packer #(
    .IMG_PIX(NPIX0), .TIMEOUT_CYC(TO), .HDR_EN(1'b0)
  ) u0 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data0), .rx_done(rx_done0),
    .ram_wren(wren0), .ram_wraddr(addr0),
    .ram_wrdata(data0), .frame_done(fd0),
    .err_timeout(err0), .busy(busy0),
    .frame_cnt(fcnt0), .LED(led0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    rx_data0 = b;
    rx_done0 = 1'b1;
    @(negedge clk);
    rx_done0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    idle(3);
    chk("rst_flags",
        {ram_wren, frame_done, err_timeout, busy, LED}, 0);
    chk("rst_addr", ram_wraddr, 0);
    chk("rst_data", ram_wrdata, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_u0",
        {wren0, fd0, err0, busy0, led0, addr0, data0, fcnt0}, 0);
    rst = 1'b0;
    idle(1);

    // headerless instance
    chk("h0_busy_idle", busy0, 0);
    send0(8'h12);
    chk("h0_busy_first", busy0, 1);
    send0(8'h34);
    chk("h0_wr0", {wren0, addr0, data0}, {1'b1, 16'h0, 16'h1234});
    for (int i = 1; i < NPIX0; i++) begin
      send0(8'h00);
      send0(8'(i));
      chk("h0_wr", {wren0, addr0, data0}, {1'b1, 16'(i), 16'(i)});
    end
    chk("h0_end", {fd0, fcnt0, led0, busy0}, {1'b1, 8'd1, 1'b1, 1'b1});
    idle(1);
    chk("h0_after", {busy0, fd0, wren0}, 0);
    seen = 1'b0;
    for (int k = 0; k < TO + 5; k++) begin
      @(negedge clk);
      if (err0) seen = 1'b1;
    end
    chk("h0_no_to_idle", seen, 0);
    send0(8'h55);
    chk("h0_busy_55", busy0, 1);
    idle(TO - 1);
    chk("h0_to_early", err0, 0);
    idle(1);
    chk("h0_to", {err0, busy0}, {1'b1, 1'b0});
    send0(8'h66);
    send0(8'h77);
    chk("h0_after_to", {wren0, addr0, data0}, {1'b1, 16'h0, 16'h6677});

    // header then first pixel
    send(8'hA5);
    chk("hdr_busy", busy, 1);
    send(8'h5A);
    send(8'h12);
    chk("no_wr_hi", ram_wren, 0);
    send(8'h34);
    chk("px0", {ram_wren, ram_wraddr, ram_wrdata, busy},
        {1'b1, 16'h0, 16'h1234, 1'b1});
    for (int i = 1; i < NPIX; i++) begin
      send(8'h00);
      send(8'(i));
      chk("px_wr", {ram_wren, ram_wraddr, ram_wrdata},
          {1'b1, 16'(i), 16'(i)});
      chk("px_fd", frame_done, 32'(i == NPIX - 1));
    end
    chk("frame_end", {frame_cnt, LED, busy}, {8'd1, 1'b1, 1'b1});
    idle(1);
    chk("frame_after", {busy, frame_done, ram_wren}, 0);

    // repeated A5 before 5A
    send(8'hA5);
    send(8'hA5);
    send(8'h5A);
    send(8'h00);
    send(8'h01);
    chk("a5a5", {ram_wren, ram_wraddr, ram_wrdata},
        {1'b1, 16'h0, 16'h0001});
    idle(TO - 1);
    chk("to1_early", err_timeout, 0);
    idle(1);
    chk("to1", {err_timeout, busy}, {1'b1, 1'b0});
    idle(1);
    chk("to1_pulse", err_timeout, 0);

    // broken header returns to IDLE
    send(8'hA5);
    send(8'h00);
    chk("badhdr_busy", busy, 0);
    send(8'h5A);
    send(8'h12);
    send(8'h34);
    chk("badhdr_nowr", {ram_wren, busy}, 0);

    // partial frame then timeout, then fresh frame
    send(8'hA5);
    send(8'h5A);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(TO - 1);
    chk("to2_early", err_timeout, 0);
    idle(1);
    chk("to2", {err_timeout, frame_done}, {1'b1, 1'b0});
    send(8'hA5);
    send(8'h5A);
    send(8'hAB);
    send(8'hCD);
    chk("after_to", {ram_wren, ram_wraddr, ram_wrdata},
        {1'b1, 16'h0, 16'hABCD});

    // byte on the exact terminal cycle wins
    seen = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge clk);
      if (err_timeout) seen = 1'b1;
    end
    send(8'h77);
    chk("race_no_to", {seen, err_timeout, busy}, {2'b00, 1'b1});
    send(8'h88);
    chk("race_byte", {ram_wren, ram_wraddr, ram_wrdata},
        {1'b1, 16'h1, 16'h7788});

    // reset mid-frame
    for (int i = 2; i < 6; i++) begin
      send(8'hC0);
      send(8'(i));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {ram_wren, ram_wraddr, ram_wrdata,
        frame_done, err_timeout, busy, frame_cnt, LED}, 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    send(8'h12);
    send(8'h34);
    chk("rst_need_hdr", {ram_wren, busy}, 0);

    // full frame after reset, then back-to-back next header
    send(8'hA5);
    send(8'h5A);
    for (int i = 0; i < NPIX; i++) begin
      send(8'hF0 ^ 8'(i));
      send(8'(i));
      chk("f2_wr", {ram_wren, ram_wraddr, ram_wrdata},
          {1'b1, 16'(i), 8'hF0 ^ 8'(i), 8'(i)});
    end
    chk("f2_end", {frame_done, frame_cnt, LED},
        {1'b1, 8'd1, 1'b1});
    send(8'hA5);
    send(8'h5A);
    send(8'hBE);
    send(8'hEF);
    chk("b2b_hdr", {ram_wren, ram_wraddr, ram_wrdata},
        {1'b1, 16'h0, 16'hBEEF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
